// File: rtl/interrupt_pkg.sv
// interrupt_pkg: definitions shared between the interrupt responder and the
// interrupt controller. The controller watches the hazard-state code and drops
// its request when it reads ST_ACCEPT (4'b0010), so these encodings are a
// cross-block contract and must not be renumbered.
package interrupt_pkg;

    localparam int DEFAULT_PC_WIDTH = 14;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0000,
        ST_WAIT   = 4'b0001,
        ST_ACCEPT = 4'b0010,
        ST_FLUSH  = 4'b0011,
        ST_VECTOR = 4'b0100,
        ST_RETURN = 4'b0101
    } state_e;

endpackage

// File: rtl/interrupt_responder_if.sv
// interrupt_responder_if: bundle between the interrupt responder and its
// environment (interrupt controller, decoder and PC/pipeline logic).
//   slave  : responder side  - takes interrupt/int_vec_addr/instr_boundary/
//            pc_current/reti, drives hazard_unit_state, int_ack, stall, flush,
//            pc_load, pc_load_addr, int_active, nest_depth and the sticky
//            stack_overflow / stack_underflow flags.
//   master : environment side - the mirror image.
interface interrupt_responder_if
    import interrupt_pkg::*;
#(
    parameter int PC_WIDTH    = DEFAULT_PC_WIDTH,
    parameter int STACK_DEPTH = 4
);
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    logic                interrupt;
    logic [PC_WIDTH-1:0] int_vec_addr;
    logic                instr_boundary;
    logic [PC_WIDTH-1:0] pc_current;
    logic                reti;
    logic [3:0]          hazard_unit_state;
    logic                int_ack;
    logic                stall;
    logic                flush;
    logic                pc_load;
    logic [PC_WIDTH-1:0] pc_load_addr;
    logic                int_active;
    logic [DEPTH_W-1:0]  nest_depth;
    logic                stack_overflow;
    logic                stack_underflow;

    modport slave (
        input  interrupt, int_vec_addr, instr_boundary, pc_current, reti,
        output hazard_unit_state, int_ack, stall, flush, pc_load, pc_load_addr,
               int_active, nest_depth, stack_overflow, stack_underflow
    );

    modport master (
        output interrupt, int_vec_addr, instr_boundary, pc_current, reti,
        input  hazard_unit_state, int_ack, stall, flush, pc_load, pc_load_addr,
               int_active, nest_depth, stack_overflow, stack_underflow
    );

endinterface

// File: rtl/return_address_stack.sv
// return_address_stack: synchronous LIFO of saved return addresses.
//   clock, reset : rising-edge clock, synchronous active-high reset (depth only)
//   push, din    : store din on top (ignored when full)
//   pop          : discard the top entry (ignored when empty)
//   top          : current top entry, 0 when empty
//   depth        : number of stored entries
//   full, empty  : depth == STACK_DEPTH / depth == 0
module return_address_stack
    import interrupt_pkg::*;
#(
    parameter int PC_WIDTH    = DEFAULT_PC_WIDTH,
    parameter int STACK_DEPTH = 4
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               push,
    input  logic                               pop,
    input  logic [PC_WIDTH-1:0]                din,
    output logic [PC_WIDTH-1:0]                top,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               full,
    output logic                               empty
);
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam int AW      = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [PC_WIDTH-1:0] mem_q [STACK_DEPTH];
    logic [DEPTH_W-1:0]  depth_q, depth_d;
    logic [AW-1:0]       wr_idx, rd_idx;
    logic                do_push, do_pop;

    assign full   = (depth_q == DEPTH_W'(STACK_DEPTH));
    assign empty  = (depth_q == '0);
    assign wr_idx = AW'(depth_q);
    assign rd_idx = AW'(depth_q - DEPTH_W'(1));
    assign top    = empty ? '0 : mem_q[rd_idx];
    assign depth  = depth_q;

    // The responder never pushes and pops in the same cycle; should both
    // arrive anyway, neither takes effect so the stack stays consistent.
    assign do_push = push && !full && !pop;
    assign do_pop  = pop && !empty && !push;

    always_comb begin
        depth_d = depth_q;
        if (do_push) begin
            depth_d = depth_q + DEPTH_W'(1);
        end else if (do_pop) begin
            depth_d = depth_q - DEPTH_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

    // Entries are not reset: depth alone decides what is valid.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/interrupt_responder.sv
// interrupt_responder: CPU-side interrupt entry/exit sequencer.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : interrupt request + vector, instruction boundary, return
//                  address, RETI pulse in; hazard state code, int_ack, stall,
//                  flush, pc_load/pc_load_addr, nesting status and sticky
//                  overflow/underflow flags out.
// Sequence: IDLE -> WAIT (for a boundary) -> ACCEPT (push return address,
// latch vector) -> FLUSH (FLUSH_CYCLES) -> VECTOR (load PC) -> IDLE, and
// IDLE -> RETURN (load PC from stack, pop on exit) -> IDLE for RETI.
module interrupt_responder
    import interrupt_pkg::*;
#(
    parameter int PC_WIDTH     = DEFAULT_PC_WIDTH,
    parameter int STACK_DEPTH  = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    interrupt_responder_if.slave bus
);
    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PC_WIDTH-1:0] vec_q, vec_d;
    logic                ovf_q, ovf_d, unf_q, unf_d;
    logic                ack_q, ack_d, stall_q, stall_d, flush_q, flush_d;
    logic                pc_load_q, pc_load_d;
    logic [PC_WIDTH-1:0] addr_q, addr_d;

    logic                push, pop, full, empty;
    logic [PC_WIDTH-1:0] top;

    return_address_stack #(
        .PC_WIDTH    (PC_WIDTH),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (bus.pc_current),
        .top   (top),
        .depth (bus.nest_depth),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push    = 1'b0;
        pop     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // RETI outranks a pending request; the controller keeps the
                // request asserted, so it is picked up on the next IDLE.
                if (bus.reti) begin
                    if (!empty) state_d = ST_RETURN;
                    else        unf_d   = 1'b1;
                end else if (bus.interrupt) begin
                    if (full) ovf_d   = 1'b1;
                    else      state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!bus.interrupt) begin
                    state_d = ST_IDLE;
                end else if (bus.instr_boundary) begin
                    state_d = ST_ACCEPT;
                    push    = 1'b1;
                    // The controller clears its vector once it sees ACCEPT.
                    vec_d   = bus.int_vec_addr;
                end
            end
            ST_ACCEPT: begin
                state_d = ST_FLUSH;
                cnt_d   = FLUSH_LOAD;
            end
            ST_FLUSH: begin
                if (cnt_q == '0) state_d = ST_VECTOR;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_VECTOR: state_d = ST_IDLE;
            ST_RETURN: begin
                state_d = ST_IDLE;
                pop     = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with
        // state_q, i.e. Moore outputs without a decode path on the pins.
        ack_d     = (state_d == ST_ACCEPT);
        stall_d   = state_d inside {ST_ACCEPT, ST_FLUSH, ST_VECTOR, ST_RETURN};
        flush_d   = state_d inside {ST_FLUSH, ST_RETURN};
        pc_load_d = state_d inside {ST_VECTOR, ST_RETURN};
        addr_d    = '0;
        if (state_d == ST_VECTOR) begin
            addr_d = vec_d;
        end else if (state_d == ST_RETURN) begin
            addr_d = top;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            vec_q     <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            ack_q     <= 1'b0;
            stall_q   <= 1'b0;
            flush_q   <= 1'b0;
            pc_load_q <= 1'b0;
            addr_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            vec_q     <= vec_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            ack_q     <= ack_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
            pc_load_q <= pc_load_d;
            addr_q    <= addr_d;
        end
    end

    assign bus.hazard_unit_state = state_q;
    assign bus.int_ack           = ack_q;
    assign bus.stall             = stall_q;
    assign bus.flush             = flush_q;
    assign bus.pc_load           = pc_load_q;
    assign bus.pc_load_addr      = addr_q;
    assign bus.int_active        = !empty;
    assign bus.stack_overflow    = ovf_q;
    assign bus.stack_underflow   = unf_q;

endmodule

// File: tb/tb_interrupt_responder.sv
// tb_interrupt_responder: scoreboard bench for interrupt_responder.
// Each stimulus task pushes the strobe pattern it expects (int_ack, stall,
// flush, pc_load/pc_load_addr, nest_depth) with its cycle number into exp_q;
// the monitor compares every cycle on the falling edge. Return addresses are
// modelled with a plain queue used as a LIFO.
module tb_interrupt_responder;
    import interrupt_pkg::*;

    localparam int PW = 14;
    localparam int SD = 4;
    localparam int FC = 2;

    typedef struct {
        int            cyc;
        logic          ack;
        logic          stall;
        logic          flush;
        logic          pc_load;
        logic [PW-1:0] addr;
        int            depth;
    } rec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   vectors = 0;
    int   miscompares = 0;
    bit   mon_en = 1'b0;
    bit   exp_ovf = 1'b0;
    bit   exp_unf = 1'b0;

    rec_t          exp_q[$];
    logic [PW-1:0] model[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    interrupt_responder_if #(.PC_WIDTH(PW), .STACK_DEPTH(SD)) bus ();

    interrupt_responder #(
        .PC_WIDTH     (PW),
        .STACK_DEPTH  (SD),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic rec_t mk(input int c, input logic a, input logic s, input logic f,
                                input logic p, input logic [PW-1:0] ad, input int d);
        rec_t r;
        r.cyc = c; r.ack = a; r.stall = s; r.flush = f; r.pc_load = p; r.addr = ad; r.depth = d;
        return r;
    endfunction

    // Expected service of a request sampled in IDLE at cycle k that waits
    // w extra cycles for a boundary.
    task automatic push_int_records(input int k, input int w, input logic [PW-1:0] vec,
                                    input int depth);
        exp_q.push_back(mk(k + w + 2, 1'b1, 1'b1, 1'b0, 1'b0, '0, depth));
        for (int i = 0; i < FC; i++)
            exp_q.push_back(mk(k + w + 3 + i, 1'b0, 1'b1, 1'b1, 1'b0, '0, depth));
        exp_q.push_back(mk(k + w + 3 + FC, 1'b0, 1'b1, 1'b0, 1'b1, vec, depth));
    endtask

    always @(negedge clock) begin
        if (mon_en) begin : monitor
            rec_t e;
            e = mk(cyc, 1'b0, 1'b0, 1'b0, 1'b0, '0, -1);
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) e = exp_q.pop_front();
            chk("int_ack", bus.int_ack, e.ack);
            chk("stall", bus.stall, e.stall);
            chk("flush", bus.flush, e.flush);
            chk("pc_load", bus.pc_load, e.pc_load);
            chk("pc_load_addr", bus.pc_load_addr, e.addr);
            if (e.depth >= 0) chk("nest_depth", bus.nest_depth, e.depth);
        end
    end

    task automatic next();
        @(posedge clock);
        #1;
    endtask

    task automatic do_int(input logic [PW-1:0] vec, input logic [PW-1:0] pc, input int w);
        int k;
        k = cyc;
        bus.interrupt = 1'b1;
        bus.int_vec_addr = vec;
        bus.pc_current = pc;
        bus.instr_boundary = 1'b0;
        if (model.size() == SD) begin
            exp_ovf = 1'b1;
            next();
            bus.interrupt = 1'b0;
            chk("ovf_state", bus.hazard_unit_state, ST_IDLE);
            chk("stack_overflow", bus.stack_overflow, exp_ovf);
            chk("ovf_depth", bus.nest_depth, SD);
            next();
            return;
        end
        model.push_back(pc);
        push_int_records(k, w, vec, model.size());
        for (int i = 1; i <= w + 1; i++) begin
            next();
            chk("wait_state", bus.hazard_unit_state, ST_WAIT);
            bus.instr_boundary = (i == w + 1);
        end
        next();
        bus.interrupt = 1'b0;
        bus.instr_boundary = 1'b0;
        bus.int_vec_addr = '0;
        bus.pc_current = PW'($urandom);
        repeat (FC + 1) next();
        next();
        chk("depth_after_int", bus.nest_depth, model.size());
    endtask

    task automatic do_reti();
        int k;
        k = cyc;
        bus.reti = 1'b1;
        if (model.size() > 0) begin
            exp_q.push_back(mk(k + 1, 1'b0, 1'b1, 1'b1, 1'b1, model[$], model.size()));
            void'(model.pop_back());
        end else begin
            exp_unf = 1'b1;
        end
        next();
        bus.reti = 1'b0;
        chk("stack_underflow", bus.stack_underflow, exp_unf);
        next();
        chk("depth_after_reti", bus.nest_depth, model.size());
        chk("int_active", bus.int_active, model.size() != 0);
    endtask

    task automatic do_both(input logic [PW-1:0] vec, input logic [PW-1:0] pc);
        int k;
        k = cyc;
        bus.reti = 1'b1;
        bus.interrupt = 1'b1;
        bus.int_vec_addr = vec;
        bus.pc_current = pc;
        bus.instr_boundary = 1'b1;
        exp_q.push_back(mk(k + 1, 1'b0, 1'b1, 1'b1, 1'b1, model[$], model.size()));
        void'(model.pop_back());
        model.push_back(pc);
        push_int_records(k + 2, 0, vec, model.size());
        next();
        bus.reti = 1'b0;
        next();
        next();
        chk("both_wait_state", bus.hazard_unit_state, ST_WAIT);
        next();
        bus.interrupt = 1'b0;
        bus.instr_boundary = 1'b0;
        bus.int_vec_addr = '0;
        repeat (FC + 1) next();
        next();
        chk("depth_after_both", bus.nest_depth, model.size());
    endtask

    task automatic do_withdraw(input int m);
        if (model.size() == SD) begin
            do_int(PW'($urandom), PW'($urandom), 0);
            return;
        end
        bus.interrupt = 1'b1;
        bus.int_vec_addr = PW'($urandom);
        bus.instr_boundary = 1'b0;
        for (int i = 1; i <= m; i++) begin
            next();
            chk("withdraw_wait", bus.hazard_unit_state, ST_WAIT);
        end
        bus.interrupt = 1'b0;
        next();
        chk("withdraw_idle", bus.hazard_unit_state, ST_IDLE);
        chk("withdraw_depth", bus.nest_depth, model.size());
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_state"}, bus.hazard_unit_state, ST_IDLE);
        chk({tag, "_ack"}, bus.int_ack, 1'b0);
        chk({tag, "_stall"}, bus.stall, 1'b0);
        chk({tag, "_flush"}, bus.flush, 1'b0);
        chk({tag, "_pc_load"}, bus.pc_load, 1'b0);
        chk({tag, "_addr"}, bus.pc_load_addr, '0);
        chk({tag, "_depth"}, bus.nest_depth, '0);
        chk({tag, "_active"}, bus.int_active, 1'b0);
        chk({tag, "_ovf"}, bus.stack_overflow, 1'b0);
        chk({tag, "_unf"}, bus.stack_underflow, 1'b0);
    endtask

    initial begin
        bus.interrupt = 1'b0;
        bus.int_vec_addr = '0;
        bus.instr_boundary = 1'b0;
        bus.pc_current = '0;
        bus.reti = 1'b0;
        reset = 1'b1;
        repeat (3) next();
        chk_all_zero("reset");
        reset = 1'b0;
        mon_en = 1'b1;
        next();

        // Basic entry and return.
        do_int(14'h0001, 14'h0100, 0);
        chk("active_after_int", bus.int_active, 1'b1);
        do_reti();

        // Boundary held off for six cycles, then a withdrawn request.
        do_int(14'h0123, 14'h0abc, 6);
        do_reti();
        do_withdraw(3);

        // Four nested interrupts, the fifth overflows, then LIFO unwinding.
        for (int i = 1; i <= 4; i++) do_int(PW'(i * 16), PW'(i * 256), i % 2);
        do_int(14'h0050, 14'h0500, 0);
        for (int i = 0; i < 4; i++) do_reti();

        // RETI with an empty stack, then RETI and request together.
        do_reti();
        do_int(14'h0222, 14'h0777, 0);
        do_both(14'h0333, 14'h0888);
        do_reti();

        // Randomized mix.
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 3))
                0: do_int(PW'($urandom), PW'($urandom), $urandom_range(0, 3));
                1: do_reti();
                2: if (model.size() > 0) do_both(PW'($urandom), PW'($urandom));
                   else do_int(PW'($urandom), PW'($urandom), 0);
                default: do_withdraw($urandom_range(1, 3));
            endcase
            repeat ($urandom_range(0, 2)) next();
        end
        while (model.size() > 0) do_reti();

        // Make sure both sticky flags are set before checking reset clears them.
        if (!exp_ovf) begin
            for (int i = 0; i <= SD; i++) do_int(PW'($urandom), PW'($urandom), 0);
            while (model.size() > 0) do_reti();
        end
        if (!exp_unf) do_reti();

        // Reset asserted in the middle of FLUSH.
        model.push_back(14'h0444);
        push_int_records(cyc, 0, 14'h0044, model.size());
        bus.interrupt = 1'b1;
        bus.int_vec_addr = 14'h0044;
        bus.pc_current = 14'h0444;
        bus.instr_boundary = 1'b1;
        next();
        next();
        bus.interrupt = 1'b0;
        bus.instr_boundary = 1'b0;
        next();
        chk("pre_reset_state", bus.hazard_unit_state, ST_FLUSH);
        reset = 1'b1;
        next();
        exp_q.delete();
        model.delete();
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        chk_all_zero("flush_reset");
        reset = 1'b0;
        next();

        // Recovery after reset.
        do_int(14'h0155, 14'h0266, 1);
        do_reti();
        repeat (3) next();
        chk("pending_events", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/interrupt_responder.md
# interrupt_responder

CPU-side counterpart to the interrupt controller: accepts the interrupt request and vector, waits for an instruction boundary, saves the return address on a small hardware stack, flushes the pipeline, and loads the program counter with the vector. It also services return-from-interrupt (RETI) by popping the saved address. It drives the 4-bit hazard-state code that the interrupt controller watches; code 4'b0010 tells the controller to drop its request.

## Interface

Parameters:
- PC_WIDTH, 14: program-counter / vector width.
- STACK_DEPTH, 4: maximum interrupt nesting (return-address entries); must be ≥1.
- FLUSH_CYCLES, 2: cycles that flush is held; must be ≥1.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- interrupt  in  1  level request from the interrupt controller.
- int_vec_addr  in  PC_WIDTH  vector, valid while interrupt=1.
- instr_boundary  in  1  pipeline sits at an interruptible instruction boundary.
- pc_current  in  PC_WIDTH  address of the next instruction to execute (the return address).
- reti  in  1  one-cycle pulse from the decoder on RETI.
- hazard_unit_state  out  4  current state code; fed to the interrupt controller.
- int_ack  out  1  high for exactly the ACCEPT cycle.
- stall  out  1  freezes instruction fetch/issue.
- flush  out  1  squashes in-flight instructions.
- pc_load  out  1  one-cycle PC overwrite strobe.
- pc_load_addr  out  PC_WIDTH  PC value to load; 0 when pc_load=0.
- int_active  out  1  nest_depth != 0.
- nest_depth  out  $clog2(STACK_DEPTH+1)  number of saved return addresses.
- stack_overflow  out  1  sticky; set when a request arrives with the stack full.
- stack_underflow  out  1  sticky; set when RETI arrives with the stack empty.

## Operation

The state machine is Moore: every output is decoded from the registered state and the latched registers.

States and hazard_unit_state codes:
- IDLE (0000): all strobes low. Priority order:
  1. reti=1 with depth>0: go to RETURN.
  2. reti=1 with depth=0: set stack_underflow and stay in IDLE.
  3. interrupt=1 with depth=STACK_DEPTH: set stack_overflow and stay in IDLE; the request is not accepted.
  4. interrupt=1 otherwise: go to WAIT.
- WAIT (0001): stall=0.
  - interrupt=0: go to IDLE (request withdrawn); nothing is pushed.
  - instr_boundary=1: go to ACCEPT.
  - reti is ignored in this state.
- ACCEPT (0010): int_ack=1, stall=1. On entry, push pc_current and latch int_vec_addr into vec_q. The push and latch happen on the WAIT→ACCEPT edge. Next state is FLUSH.
- FLUSH (0011): stall=1, flush=1 for FLUSH_CYCLES cycles (down-counter), then go to VECTOR.
- VECTOR (0100): stall=1, pc_load=1, pc_load_addr=vec_q. Next state is IDLE.
- RETURN (0101): stall=1, flush=1, pc_load=1, pc_load_addr=top of stack. The pop takes effect on exit. Next state is IDLE.

Rules:
- vec_q is latched because the controller clears its vector once it sees 0010.
- reti and interrupt asserted together in IDLE: RETURN wins. The controller keeps its request held, so the interrupt is taken afterwards.
- nest_depth changes only on push (ACCEPT entry, +1) and pop (RETURN exit, −1). It never wraps.
- Reset (any state, any cycle): state IDLE, depth 0, vec_q 0, flush counter 0, sticky flags 0, all outputs 0. Stack contents are don't-care.

## Timing

- interrupt rises in IDLE at cycle k with instr_boundary=1 held:
  - WAIT at k+1, ACCEPT at k+2.
  - FLUSH at k+3 through k+2+FLUSH_CYCLES.
  - VECTOR at k+3+FLUSH_CYCLES (k+5 with the default).
- Latency from request to pc_load is 3+FLUSH_CYCLES cycles, plus any extra cycles spent waiting in WAIT.
- reti pulse in IDLE at cycle k: RETURN at k+1 (pc_load there), IDLE at k+2.
- Minimum interrupt service sequence is 3+FLUSH_CYCLES cycles. Back-to-back nested acceptance is allowed immediately after VECTOR.

## Structure

- Shared package `interrupt_pkg`:
  - state codes (IDLE…RETURN as 4-bit constants; 4'b0010 = ACCEPT, shared with the interrupt controller);
  - default PC_WIDTH.
- Sub-module `return_address_stack`: synchronous LIFO parameterised by PC_WIDTH and STACK_DEPTH.
  - Inputs: push, pop, din.
  - Outputs: top, depth, full, empty.
  - Push when full and pop when empty are ignored internally.

## Test plan

- Reset, then interrupt=1, int_vec_addr=14'h0001, pc_current=14'h0100, boundary=1 at k. Required: int_ack only at k+2; flush at k+3..k+4; pc_load=1 with pc_load_addr=14'h0001 at k+5; nest_depth=1.
- After that, reti pulse. Required: pc_load with addr 14'h0100 one cycle later; nest_depth=0; int_active=0.
- instr_boundary held 0 for 6 cycles. Required: stays in WAIT (hazard_unit_state 0001) with stall=0, then proceeds 1 cycle after boundary rises. Separately, interrupt dropped while in WAIT returns to IDLE with depth unchanged.
- Five nested interrupts with STACK_DEPTH=4. Required: fifth sets stack_overflow and is not acknowledged. Four RETIs then return 14'h0400, 0300, 0200, 0100 in LIFO order.
- reti with depth 0. Required: stack_underflow=1, no pc_load. reti and interrupt together in IDLE with depth 1: RETURN taken first, interrupt accepted after.
- reset asserted during FLUSH. Required: next cycle all outputs 0, state IDLE, depth 0, sticky flags cleared.
